// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter/sequencer sharing one combinational ALU
// among NREQ requesters, with a single tagged, backpressured response channel.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid / req_ready    per-requester handshake (req_ready one-hot, combinational)
//   req_a, req_b, req_op     packed per-requester operands and opcode (slice i = requester i)
//   alu_a, alu_b, alu_op     operand registers driving the external ALU
//   alu_out, alu_*           ALU result and flags
//   resp_valid / resp_ready  response handshake
//   resp_id, resp_out,       answered requester index, result, captured flags,
//   resp_zero/carry/overflow/sign, resp_err (unsupported opcode)
module alu_arbiter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NREQ  = 4,
    parameter int unsigned IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ*4-1:0]     req_op,
    output logic [WIDTH-1:0]      alu_a,
    output logic [WIDTH-1:0]      alu_b,
    output logic [3:0]            alu_op,
    input  logic [WIDTH-1:0]      alu_out,
    input  logic                  alu_zero,
    input  logic                  alu_carry,
    input  logic                  alu_overflow,
    input  logic                  alu_sign,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [IDW-1:0]        resp_id,
    output logic [WIDTH-1:0]      resp_out,
    output logic                  resp_zero,
    output logic                  resp_carry,
    output logic                  resp_overflow,
    output logic                  resp_sign,
    output logic                  resp_err
);

    localparam int unsigned OPW = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   winner;
    logic [IDW-1:0]   cand;
    logic             any_valid;
    logic             accept;
    logic             win_sup;
    logic [WIDTH-1:0] win_a;
    logic [WIDTH-1:0] win_b;
    logic [OPW-1:0]   win_op;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [OPW-1:0]   op_op;
    logic [IDW-1:0]   op_id;

    // Rotating priority search starting just after the last winner
    always_comb begin
        any_valid = 1'b0;
        winner    = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = IDW'((32'(ptr) + k) % NREQ);
            if (!any_valid && req_valid[cand]) begin
                any_valid = 1'b1;
                winner    = cand;
            end
        end
    end

    // Winner payload mux
    assign win_a  = req_a[32'(winner)*WIDTH +: WIDTH];
    assign win_b  = req_b[32'(winner)*WIDTH +: WIDTH];
    assign win_op = req_op[32'(winner)*OPW +: OPW];

    // Opcodes the ALU implements; anything else is answered with resp_err
    always_comb begin
        win_sup = 1'b0;
        case (win_op)
            4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h7, 4'h8, 4'h9: win_sup = 1'b1;
            default:                                          win_sup = 1'b0;
        endcase
    end

    // Accept in IDLE, or in RESP the same cycle the response is consumed
    assign accept = any_valid && ((state == IDLE) || ((state == RESP) && resp_ready));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = win_sup ? ISSUE : RESP;
                end
            end
            ISSUE: begin
                state_nxt = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    if (accept) begin
                        state_nxt = win_sup ? ISSUE : RESP;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Handshake outputs
    always_comb begin
        req_ready  = '0;
        resp_valid = 1'b0;
        if (accept) begin
            req_ready[winner] = 1'b1;
        end
        resp_valid = (state == RESP);
    end

    // Operand latch on accept; response capture in ISSUE or directly on an error accept
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr           <= IDW'(NREQ - 1);
            op_a          <= '0;
            op_b          <= '0;
            op_op         <= '0;
            op_id         <= '0;
            resp_id       <= '0;
            resp_out      <= '0;
            resp_zero     <= 1'b0;
            resp_carry    <= 1'b0;
            resp_overflow <= 1'b0;
            resp_sign     <= 1'b0;
            resp_err      <= 1'b0;
        end else begin
            if (accept) begin
                op_a  <= win_a;
                op_b  <= win_b;
                op_op <= win_op;
                op_id <= winner;
                ptr   <= winner;
                if (!win_sup) begin
                    resp_id       <= winner;
                    resp_out      <= '0;
                    resp_zero     <= 1'b0;
                    resp_carry    <= 1'b0;
                    resp_overflow <= 1'b0;
                    resp_sign     <= 1'b0;
                    resp_err      <= 1'b1;
                end
            end
            if (state == ISSUE) begin
                resp_id       <= op_id;
                resp_out      <= alu_out;
                resp_zero     <= alu_zero;
                resp_carry    <= alu_carry;
                resp_overflow <= alu_overflow;
                resp_sign     <= alu_sign;
                resp_err      <= 1'b0;
            end
        end
    end

    assign alu_a  = op_a;
    assign alu_b  = op_b;
    assign alu_op = op_op;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer that shares one combinational `alu` instance among `NREQ` requesters. Each requester presents operands and an opcode with a valid/ready handshake. The arbiter latches the winning request, drives the ALU from registers, and captures result and flags. It returns them on a single tagged response channel with backpressure. It sits between the issue logic of several clients and the shared ALU datapath.

## Interface
- `WIDTH`, 32: operand/result width; passed to the ALU.
- `NREQ`, 4: number of requesters, 2..16.
- `IDW`, $clog2(NREQ): requester-index width.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_ready`  out  NREQ  one-hot accept strobe; at most one bit set.
- `req_a`  in  NREQ*WIDTH  operand A; slice i belongs to requester i.
- `req_b`  in  NREQ*WIDTH  operand B; slice i belongs to requester i.
- `req_op`  in  NREQ*4  opcode; slice i belongs to requester i.
- `alu_a`, `alu_b`  out  WIDTH  to ALU `a`/`b`, driven from operand registers.
- `alu_op`  out  4  to ALU `opcode`, driven from operand register.
- `alu_out`  in  WIDTH  from ALU `out`.
- `alu_zero`, `alu_carry`, `alu_overflow`, `alu_sign`  in  1  ALU flags.
- `resp_valid`  out  1  response valid.
- `resp_ready`  in  1  response consumer ready.
- `resp_id`  out  IDW  index of the requester being answered.
- `resp_out`  out  WIDTH  result.
- `resp_zero`, `resp_carry`, `resp_overflow`, `resp_sign`  out  1  captured flags.
- `resp_err`  out  1  unsupported opcode; result and flags forced to 0.

## Operation
- **Supported opcodes:**
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
  - 0111 SLL, 1000 SRL, 1001 SRA.
  - All others (0101, 0110, 1010–1111) are unsupported.
- **States:** IDLE, ISSUE, RESP.
- **Grant:** the first i with `req_valid[i]=1`, searching ptr+1, ptr+2, … modulo NREQ. `ptr` is set to the winner on every accept.
- **Accept:** in IDLE, or in RESP when `resp_ready=1`, if any `req_valid` is set:
  - `req_ready[winner]=1` for that cycle (combinational from state and `req_valid`).
  - Latch the winner's a, b, op and id into the operand registers.
  - Next state is ISSUE if the opcode is supported, otherwise RESP with `resp_err=1` and ALU not used.
- **ISSUE:** the operand registers drive the ALU. Register `alu_out` and the four flags into the response registers with `resp_err=0`. Go to RESP.
- **RESP:** `resp_valid=1`; the response registers are held stable while `resp_ready=0`.
  - `resp_ready=1` with no pending request → IDLE.
  - `resp_ready=1` with a pending request → accept as above (back-to-back).
- **Requester obligations:** `req_valid` and its payload are held until `req_ready` is seen. The arbiter samples the payload only in the accept cycle.
- **ALU usage:** the ALU is purely combinational. No arithmetic is done in this block; widths pass through unchanged.

## Timing
- **Reset values:**
  - State IDLE; `ptr`=NREQ-1, so requester 0 has first priority.
  - Operand and response registers 0, so `alu_a`/`alu_b`/`alu_op` are 0.
  - `req_ready`=0, `resp_valid`=0, `resp_id`=0, `resp_out`=0, all flags 0, `resp_err`=0.
- **Latency:** accept in cycle T → `resp_valid` from cycle T+2 for supported opcodes, T+1 for unsupported.
- **Throughput:** with `resp_ready` held high, one response every 2 cycles (supported) or every cycle (unsupported).
- **Simultaneous requests:** exactly one grant per accept cycle. Losers keep `req_valid` and are served in rotation; no requester waits more than NREQ-1 grants.
- **Backpressure:** while RESP and `resp_ready=0`, `req_ready`=0 for all requesters and the response is unchanged.
- **Reset mid-operation:** in-flight request and response are discarded, no response is emitted, and `ptr` returns to NREQ-1.

## Test plan
- **Single ADD:** after reset, req0 a=5, b=3, op=0000 → `req_ready[0]` in the same cycle; 2 cycles later `resp_valid`=1, `resp_id`=0, `resp_out`=8, `resp_zero`=0, `resp_err`=0.
- **Round-robin with backpressure:** all four requesters assert simultaneously and hold: req0 SUB 0xA−3, req1 AND F0F0F0F0&0F0F0F0F, req2 SRA 0x80000000 by 1, req3 SUB 5−5. With `resp_ready` high → `resp_id` order 0, 1, 2, 3; outputs 7, 0 (`resp_zero`=1), 0xC0000000 (`resp_sign`=1), 0 (`resp_zero`=1); responses 2 cycles apart.
- **Unsupported opcode:** req1 op=0101 → response 1 cycle after accept; `resp_err`=1, `resp_out`=0, all flags 0. The following req1 ADD succeeds normally.
- **Backpressure hold:** req2 XOR F0F0F0F0^0F0F0F0F with `resp_ready` low for 5 cycles → `resp_out`=FFFFFFFF held stable. Meanwhile req0 is pending with `req_ready[0]`=0. Raise `resp_ready` → req0 accepted in that cycle.
- **Fairness:** req0 holds `req_valid` continuously while req3 requests once → req3 granted no later than the second accept after it asserts.
- **Reset mid-operation:** assert `rst` during ISSUE of req1 SLL 1<<4 → no response emitted. After release, a fresh req1 SLL returns 0x10 with `resp_id`=1.
